// File: rtl/clkdiv_arbiter.sv
// rtl/clkdiv_arbiter.sv - round-robin arbiter sharing one programmable divider
// Owner runs div_clk/tick for a latched number of toggles, then gets a done pulse.
module clkdiv_arbiter #(
   parameter int NREQ = 4,
   parameter int CW   = 32,
   parameter int TW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CW-1:0]   upto,
   input  logic [NREQ*TW-1:0]   ntog,
   output logic [NREQ-1:0]      grant,
   output logic                 busy,
   output logic                 div_clk,
   output logic                 tick,
   output logic [NREQ-1:0]      done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t            state_q;
   logic [IW-1:0]     ptr_q, owner_q;
   logic [CW-1:0]     upto_l_q, cnt_q;
   logic [TW-1:0]     ntog_l_q, tog_left_q;
   logic [NREQ-1:0]   grant_q, done_q;
   logic              busy_q, div_clk_q, tick_q;

   logic              pick_vld;
   logic [IW-1:0]     pick_idx, scan_idx, ptr_d;
   logic              abort;

   // Scan from the far end so the requester closest to the pointer wins last.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         scan_idx = IW'((int'(ptr_q) + i) % NREQ);
         if (req[scan_idx]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx;
         end
      end
   end

   assign ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
   assign abort = ((state_q == S_LOAD) || (state_q == S_RUN)) && !req[owner_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         upto_l_q   <= '0;
         ntog_l_q   <= '0;
         cnt_q      <= '0;
         tog_left_q <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         div_clk_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         done_q <= '0;
         if (abort) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            div_clk_q <= 1'b0;
            ptr_q     <= ptr_d;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (pick_vld) begin
                     state_q  <= S_LOAD;
                     owner_q  <= pick_idx;
                     grant_q  <= NREQ'(1) << pick_idx;
                     busy_q   <= 1'b1;
                     upto_l_q <= upto[int'(pick_idx)*CW +: CW];
                     ntog_l_q <= ntog[int'(pick_idx)*TW +: TW];
                  end
               end
               S_LOAD: begin
                  cnt_q      <= '0;
                  tog_left_q <= ntog_l_q;
                  if (ntog_l_q == '0) begin
                     state_q   <= S_DONE;
                     done_q    <= grant_q;
                     div_clk_q <= 1'b0;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
               S_RUN: begin
                  // The final tick gets its own cycle so it never coincides with done.
                  if (tog_left_q == '0) begin
                     state_q   <= S_DONE;
                     done_q    <= grant_q;
                     div_clk_q <= 1'b0;
                  end else if (cnt_q == upto_l_q) begin
                     cnt_q      <= '0;
                     div_clk_q  <= ~div_clk_q;
                     tick_q     <= 1'b1;
                     tog_left_q <= tog_left_q - TW'(1);
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_DONE: begin
                  state_q   <= S_IDLE;
                  grant_q   <= '0;
                  busy_q    <= 1'b0;
                  div_clk_q <= 1'b0;
                  ptr_q     <= ptr_d;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign grant   = grant_q;
   assign busy    = busy_q;
   assign div_clk = div_clk_q;
   assign tick    = tick_q;
   assign done    = done_q;

endmodule

// File: tb/tb_clkdiv_arbiter.sv
// tb/tb_clkdiv_arbiter.sv - directed and random checks of clkdiv_arbiter
// Expected outputs come from a closed-form timeline model of each grant.
module tb_clkdiv_arbiter;

   localparam int NREQ = 4;
   localparam int CW   = 32;
   localparam int TW   = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ*CW-1:0]  upto;
   logic [NREQ*TW-1:0]  ntog;
   logic [NREQ-1:0]     grant;
   logic                busy;
   logic                div_clk;
   logic                tick;
   logic [NREQ-1:0]     done;

   clkdiv_arbiter #(.NREQ(NREQ), .CW(CW), .TW(TW)) dut (
      .clk(clk), .rst(rst), .req(req), .upto(upto), .ntog(ntog),
      .grant(grant), .busy(busy), .div_clk(div_clk), .tick(tick), .done(done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: whether a grant is live, its owner, cycles since grant, latched period/count.
   bit m_act = 0;
   int m_own = 0, m_r = 0, m_u = 0, m_t = 0, m_ptr = 0;
   bit auto_drop = 1;

   int obs_ticks = 0, obs_dones = 0;
   logic [NREQ-1:0] grant_log[$];
   logic [NREQ-1:0] prev_grant = '0;

   function automatic int m_end();
      return (m_t == 0) ? 1 : 2 + m_t * (m_u + 1);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [NREQ-1:0] eg, ed;
      logic eb, et, ec;
      int k;
      eg = '0; ed = '0; eb = 1'b0; et = 1'b0; ec = 1'b0;
      if (m_act) begin
         eg = NREQ'(1) << m_own;
         eb = 1'b1;
         if (m_r >= 1 && m_r < m_end()) begin
            k  = (m_r - 1) / (m_u + 1);
            et = (m_r > 1) && ((m_r - 1) % (m_u + 1) == 0);
            ec = k[0];
         end
         if (m_r == m_end()) ed = eg;
      end
      chk("grant", grant, eg);
      chk("busy", busy, eb);
      chk("tick", tick, et);
      chk("div_clk", div_clk, ec);
      chk("done", done, ed);
      if (tick === 1'b1) obs_ticks++;
      if (done !== '0) obs_dones++;
      if (grant !== '0 && prev_grant === '0) grant_log.push_back(grant);
      prev_grant = grant;
   endtask

   task automatic model_edge();
      if (rst) begin
         m_act = 0;
         m_ptr = 0;
      end else if (m_act) begin
         if (m_r == m_end() || !req[m_own]) begin
            m_act = 0;
            m_ptr = (m_own + 1) % NREQ;
         end else begin
            m_r++;
         end
      end else if (req != '0) begin
         for (int d = 0; d < NREQ; d++) begin
            if (req[(m_ptr + d) % NREQ]) begin
               m_own = (m_ptr + d) % NREQ;
               break;
            end
         end
         m_act = 1;
         m_r   = 0;
         m_u   = int'(upto[m_own*CW +: CW]);
         m_t   = int'(ntog[m_own*TW +: TW]);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      if (auto_drop && m_act && m_r == m_end()) req[m_own] = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_fields(input int i, input int u, input int t);
      upto[i*CW +: CW] = CW'(u);
      ntog[i*TW +: TW] = TW'(t);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      obs_ticks = 0;
      obs_dones = 0;
      grant_log.delete();
   endtask

   initial begin
      req = '0; upto = '0; ntog = '0; rst = 1'b1;
      @(negedge clk);
      do_reset();
      chk("reset_grant", grant, '0);
      chk("reset_busy", busy, 1'b0);

      // 1: basic run, four toggles, period 4
      set_fields(0, 3, 4);
      req = 4'b0001;
      run(24);
      chk("t1_ticks", obs_ticks, 4);
      chk("t1_dones", obs_dones, 1);
      chk("t1_grant_after", grant, '0);

      // 2: all requesting, round-robin order
      do_reset();
      auto_drop = 0;
      for (int i = 0; i < NREQ; i++) set_fields(i, 0, 1);
      req = 4'b1111;
      run(25);
      req = '0;
      run(3);
      auto_drop = 1;
      chk("t2_ngrants", grant_log.size(), 5);
      chk("t2_g0", grant_log[0], 4'b0001);
      chk("t2_g1", grant_log[1], 4'b0010);
      chk("t2_g2", grant_log[2], 4'b0100);
      chk("t2_g3", grant_log[3], 4'b1000);
      chk("t2_g4", grant_log[4], 4'b0001);
      chk("t2_ticks", obs_ticks, 5);
      chk("t2_dones", obs_dones, 5);

      // 3: zero toggle count
      do_reset();
      set_fields(2, 5, 0);
      req = 4'b0100;
      run(6);
      chk("t3_ticks", obs_ticks, 0);
      chk("t3_dones", obs_dones, 1);
      chk("t3_grant", grant_log[0], 4'b0100);

      // 4: abort after two ticks, req2 pending
      do_reset();
      set_fields(1, 9, 10);
      set_fields(2, 1, 1);
      req = 4'b0110;
      for (int i = 0; i < 100 && obs_ticks < 2; i++) step();
      chk("t4_ticks_before_drop", obs_ticks, 2);
      req[1] = 1'b0;
      run(12);
      chk("t4_dones", obs_dones, 1);
      chk("t4_ngrants", grant_log.size(), 2);
      chk("t4_second", grant_log[1], 4'b0100);

      // 5: reset mid-run
      do_reset();
      set_fields(0, 3, 4);
      set_fields(3, 2, 2);
      req = 4'b1001;
      run(8);
      do_reset();
      chk("t5_rst_grant", grant, '0);
      chk("t5_rst_div", div_clk, 1'b0);
      run(3);
      chk("t5_first", grant_log[0], 4'b0001);
      req = '0;
      run(2);

      // 6: period change after snapshot is ignored
      do_reset();
      set_fields(0, 3, 3);
      req = 4'b0001;
      run(7);
      set_fields(0, 7, 3);
      run(20);
      chk("t6_ticks", obs_ticks, 3);
      chk("t6_dones", obs_dones, 1);

      // Random traffic with aborts, field changes and occasional reset
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 7) == 0) begin
               set_fields(i, $urandom_range(0, 4), $urandom_range(0, 4));
               req[i] = 1'b1;
            end else if (req[i] && $urandom_range(0, 63) == 0) begin
               req[i] = 1'b0;
            end
         end
         if (m_act && $urandom_range(0, 15) == 0)
            set_fields(m_own, $urandom_range(0, 4), $urandom_range(0, 4));
         rst = ($urandom_range(0, 399) == 0);
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
